uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Serial receive peripheral for the minimal SoC. Consumes an 8N1 UART bit stream, such as the SoC's uart_tx line or an external host, and deserialises it with 16x oversampling.
- Received bytes are buffered in a show-ahead FIFO that the bus-side register logic reads.
- Flags framing errors (pulse) and FIFO overruns (sticky) for software.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s. Oversample divisor DIV = CLK_FREQ/(BAUD*16), truncated; DIV must be >= 1.
- FIFO_DEPTH, 16, receive FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous reset, active-high.
- rx_i, input, 1: asynchronous serial input; idle level is 1.
- rd_en, input, 1: pop the FIFO head this cycle; ignored when empty.
- clr_err, input, 1: clears overrun.
- rd_data, output, 8: FIFO head byte (show-ahead); value is undefined when empty.
- empty, output, 1: FIFO has no entries.
- full, output, 1: FIFO holds FIFO_DEPTH entries.
- count, output, $clog2(FIFO_DEPTH)+1: number of entries currently held.
- frame_err, output, 1: one-cycle pulse when a bad stop bit is sampled.
- overrun, output, 1: sticky; set when a received byte is dropped because the FIFO is full.
- busy, output, 1: receiver FSM is not in IDLE.

Behaviour:
- Reset values while rst=1, asynchronously:
  - FSM = IDLE; synchroniser flops = 1.
  - count=0, empty=1, full=0.
  - frame_err=0, overrun=0, busy=0.
  - Tick divider, bit counter and shift register cleared.
- Input sync: rx_i passes through a 2-flop synchroniser; rxs is the synchronised value.
- Tick generator: free-running divider produces a 1-clk tick every DIV clocks. It restarts at 0 when a start edge is detected.
- Oversample counter os_cnt is 4 bits, advances on each tick, and wraps 15->0.
- FSM:
  - IDLE: rxs falls 1->0 -> go to START; os_cnt=0; divider restarted.
  - START: on the tick where os_cnt==7 (mid-bit), re-sample rxs.
    - rxs=0 -> DATA; os_cnt=0; bit_cnt=0.
    - rxs=1 -> glitch, return to IDLE; no error is flagged.
  - DATA: on each tick where os_cnt==15, sample rxs into bit[bit_cnt], LSB first.
    - After bit 7 -> STOP.
  - STOP: on the tick where os_cnt==15, sample rxs.
    - rxs=1 -> push the assembled byte; go to IDLE.
    - rxs=0 -> frame_err pulses for exactly that cycle; byte discarded; go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- busy = (state != IDLE).
- Latency: the pushed byte is visible on rd_data with empty=0 on the clock after the stop-bit sample cycle.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - rd_data = mem[rd_ptr], combinational from registered state.
  - Pop when rd_en && !empty: rd_ptr+1, count-1.
  - Push while not full: write mem[wr_ptr], wr_ptr+1, count+1.
  - Push and pop in the same cycle with count>0: both occur and count is unchanged.
  - Push while full with rd_en=1 in the same cycle: both occur and the byte is accepted.
  - Push while full with no pop: byte dropped, overrun set to 1, pointers unchanged.
  - Push while empty and rd_en=1 in the same cycle: the pop is ignored and the push occurs.
- Errors:
  - overrun holds until clr_err=1, which clears it the next clock.
  - If clr_err and a new overrun occur in the same cycle, set wins (overrun=1).
- Reset asserted mid-frame aborts the frame. No partial byte is ever pushed, and after release the FSM waits for a fresh falling edge.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=100000, giving DIV=1 and 16 clks per bit. FIFO_DEPTH=4 unless stated.
1. Send 0xA5 (8N1), no reads -> one clock after the stop-bit mid sample: empty=0, count=1, rd_data=0xA5, frame_err never pulses. Pulse rd_en -> empty=1, count=0.
2. Drive rx_i low for 4 clks from idle, then high -> FSM returns to IDLE, busy drops, count=0, frame_err=0.
3. Send 0x3C with the stop bit driven 0 for 20 bit-times -> frame_err pulses exactly one cycle, count=0, busy stays 1 until rx_i returns high.
4. Send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads -> full=1, count=4, overrun=1. Four pops return 0x11, 0x22, 0x33, 0x44, then empty=1. Pulse clr_err -> overrun=0.
5. With the FIFO full, assert rd_en on the push cycle of 0x66 -> count stays 4, overrun stays 0, and the last pop returns 0x66 (checks pointer wrap).
6. Assert rst during data bit 3 of 0x81, release, then send 0x7E -> only 0x7E is received, count=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a show-ahead FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_i,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        busy
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic s1, rxs, rxs_d, tick, push, bad_stop, pop, wr, ovf;
  logic [DW-1:0] div_cnt, div_n;
  logic [3:0] os_cnt, os_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign tick = div_cnt == DW'(DIV - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      s1        <= 1'b1;
      rxs       <= 1'b1;
      rxs_d     <= 1'b1;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      s1        <= rx_i;
      rxs       <= s1;
      rxs_d     <= rxs;
      div_cnt   <= div_n;
      os_cnt    <= os_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      frame_err <= bad_stop;
    end
  always_comb begin
    state_n  = state;
    div_n    = tick ? '0 : div_cnt + 1'b1;
    os_n     = tick ? os_cnt + 1'b1 : os_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    push     = 1'b0;
    bad_stop = 1'b0;
    case (state)
      IDLE: if (rxs_d && !rxs) begin
        state_n = START;
        os_n    = '0;
        div_n   = '0;
      end
      START: if (tick && os_cnt == 4'd7) begin
        state_n = rxs ? IDLE : DATA;
        os_n    = '0;
        bit_n   = '0;
      end
      DATA: if (tick && os_cnt == 4'd15) begin
        shift_n = {rxs, shift[7:1]};
        bit_n   = bit_cnt + 1'b1;
        state_n = bit_cnt == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick && os_cnt == 4'd15) begin
        push     = rxs;
        bad_stop = !rxs;
        state_n  = rxs ? IDLE : BRK;
      end
      BRK: state_n = rxs ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign rd_data = mem[rd_ptr];
  assign pop     = rd_en && !empty;
  assign wr      = push && (!full || rd_en);
  assign ovf     = push && full && !rd_en;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= shift;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr  <= wr ? wr_ptr + 1'b1 : wr_ptr;
      count   <= count + (AW+1)'(wr) - (AW+1)'(pop);
      overrun <= ovf || (overrun && !clr_err);
    end
endmodule
